// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the MEM-stage data cache responder.
// No logic; widths derive from LINES/DEPTH (DEPTH must exceed LINES).
// No flow control lives here.
package dcache_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {IDLE, RFILL, WBUSY, DONE} state_t;

  // Line index width: one word per line, so the low word-index bits pick the line.
  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  // Tag width: word-index bits left over after the line index.
  function automatic int tag_w(input int lines, input int depth);
    return $clog2(depth) - $clog2(lines);
  endfunction

  // Counter width able to hold the larger of the two modelled latencies.
  function automatic int cnt_w(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Data/tag/valid arrays of the direct-mapped cache, one word per line.
// Read port is combinational (0 cycles); write lands on the next rising edge.
// No backpressure: a write is accepted every cycle wr_en is high.
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int TW    = 6
) (
  input  logic                     clock,
  input  logic                     reset_0,
  input  logic [idx_w(LINES)-1:0]  rd_idx,
  output logic                     rd_valid,
  output logic [TW-1:0]            rd_tag,
  output logic [WORD_W-1:0]        rd_data,
  input  logic                     wr_en,
  input  logic [idx_w(LINES)-1:0]  wr_idx,
  input  logic [TW-1:0]            wr_tag,
  input  logic [WORD_W-1:0]        wr_data
);

  logic [WORD_W-1:0] data_q [LINES];
  logic [TW-1:0]     tag_q  [LINES];
  logic [LINES-1:0]  valid_q;

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

  // Valid bits: cleared by reset, set by any line write.
  always_ff @(posedge clock) begin
    if (reset_0) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Data and tag arrays carry no reset; valid gates their use.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      data_q[wr_idx] <= wr_data;
      tag_q[wr_idx]  <= wr_tag;
    end
  end

endmodule

// File: rtl/dcache_responder.sv
// MEM-stage data responder: write-through, no-write-allocate direct-mapped cache over a modelled store.
// Latency: read hit 1 cycle, read miss MISS_LAT+1, write WR_LAT+1 (last cycle is DONE, stall low).
// Backpressure: stall holds the pipeline while a request is outstanding; DCACHE_STATS_EN adds hit/miss counters.
module dcache_responder
  import dcache_pkg::*;
#(
  parameter int LINES    = 16,
  parameter int DEPTH    = 1024,
  parameter int MISS_LAT = 4,
  parameter int WR_LAT   = 2
) (
  input  logic              clock,
  input  logic              reset_0,
  input  logic [31:0]       addr,
  input  logic              rmem,
  input  logic              wmem,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = idx_w(LINES);
  localparam int TW = tag_w(LINES, DEPTH);
  localparam int CW = cnt_w(MISS_LAT, WR_LAT);

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [WORD_W-1:0]   fill_q;
  logic [AW-1:0]       req_word_q;
  logic [WORD_W-1:0]   req_wdata_q;
  logic                req_wr_q;
  logic [WORD_W-1:0]   mem [DEPTH];

  logic                in_idle, rd_req, wr_req, hit, fill_now, commit_wr;
  logic [AW-1:0]       cur_word, lk_word;
  logic [WORD_W-1:0]   lk_wdata;
  logic                ls_valid;
  logic [TW-1:0]       ls_tag;
  logic [WORD_W-1:0]   ls_data;
  logic                unused_addr;

  assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
  assign cur_word    = addr[AW+1:2];
  assign in_idle     = (state_q == IDLE);
  assign rd_req      = rmem & ~wmem;
  assign wr_req      = wmem;

  // Outside IDLE the request captured at acceptance drives lookup and commit.
  assign lk_word  = in_idle ? cur_word : req_word_q;
  assign lk_wdata = in_idle ? wdata    : req_wdata_q;
  assign hit      = ls_valid && (ls_tag == lk_word[AW-1:IW]);

  // Fill/commit on the last counted cycle, or straight out of IDLE when the latency is 1.
  assign fill_now  = ~reset_0 & ((in_idle & rd_req & ~hit & (MISS_LAT == 1)) |
                                 ((state_q == RFILL) & (cnt_q == CW'(1))));
  assign commit_wr = ~reset_0 & ((in_idle & wr_req & (WR_LAT == 1)) |
                                 ((state_q == WBUSY) & (cnt_q == CW'(1))));

  dcache_line_store #(.LINES(LINES), .TW(TW)) u_lines (
    .clock    (clock),
    .reset_0  (reset_0),
    .rd_idx   (lk_word[IW-1:0]),
    .rd_valid (ls_valid),
    .rd_tag   (ls_tag),
    .rd_data  (ls_data),
    .wr_en    (fill_now | (commit_wr & hit)),
    .wr_idx   (lk_word[IW-1:0]),
    .wr_tag   (lk_word[AW-1:IW]),
    .wr_data  (fill_now ? mem[lk_word] : lk_wdata)
  );

  // State and latency counter registers.
  always_ff @(posedge clock) begin
    if (reset_0) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: IDLE decides, RFILL/WBUSY count down, DONE always returns to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (wr_req) begin
          state_d = (WR_LAT == 1) ? DONE : WBUSY;
          cnt_d   = CW'(WR_LAT - 1);
        end else if (rd_req && !hit) begin
          state_d = (MISS_LAT == 1) ? DONE : RFILL;
          cnt_d   = CW'(MISS_LAT - 1);
        end
      end
      RFILL, WBUSY: begin
        if (cnt_q == CW'(1)) state_d = DONE;
        cnt_d = cnt_q - CW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: hits answer in IDLE, misses and writes answer from DONE.
  always_comb begin
    stall = 1'b0;
    rdata = '0;
    case (state_q)
      IDLE: begin
        stall = wr_req | (rd_req & ~hit);
        if (rd_req && hit) rdata = ls_data;
      end
      RFILL, WBUSY: stall = 1'b1;
      DONE:    rdata = req_wr_q ? '0 : fill_q;
      default: ;
    endcase
  end

  // Request capture and fill buffer.
  always_ff @(posedge clock) begin
    if (reset_0) begin
      fill_q      <= '0;
      req_word_q  <= '0;
      req_wdata_q <= '0;
      req_wr_q    <= 1'b0;
    end else begin
      if (in_idle && (rmem || wmem)) begin
        req_word_q  <= cur_word;
        req_wdata_q <= wdata;
        req_wr_q    <= wmem;
      end
      if (fill_now) fill_q <= mem[lk_word];
    end
  end

  // Backing store: write-through, never cleared by reset.
  always_ff @(posedge clock) begin
    if (commit_wr) mem[lk_word] <= lk_wdata;
  end

`ifdef DCACHE_STATS_EN
  // Read hit/miss counters, counted on the IDLE decision cycle, saturating.
  always_ff @(posedge clock) begin
    if (reset_0) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (in_idle && rd_req) begin
      if (hit && (hit_count != '1)) hit_count <= hit_count + 32'd1;
      if (!hit && (miss_count != '1)) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Memory-side responder for the CPU's MEM-stage data port.
- Accepts address, read-enable, write-enable and write-data from the EX/MEM register; returns read data plus a stall that freezes EX/MEM, MEM/WB and ID while a request is outstanding.
- Internally: a direct-mapped, one-word-per-line, write-through, no-write-allocate cache in front of a word-addressed backing store with fixed modelled latencies.

Parameters:
- LINES, 16: cache lines; power of 2, >=2.
- DEPTH, 1024: backing-store words; power of 2.
- MISS_LAT, 4: stall cycles on a read miss; >=1.
- WR_LAT, 2: stall cycles on any write; >=1.

Ports:
- clock  in  1  CPU clock; all state updates on the rising edge.
- reset_0  in  1  synchronous, active-high reset.
- addr  in  32  byte address; bits [1:0] ignored; word index = addr[log2(DEPTH)+1:2] (wraps modulo DEPTH).
- rmem  in  1  read request.
- wmem  in  1  write request; wins if rmem is also high.
- wdata  in  32  store data.
- rdata  out  32  load data.
- stall  out  1  high = request not complete; CPU holds addr/rmem/wmem/wdata stable.

Behaviour:
- States: IDLE, RFILL, WBUSY, DONE. Counter cnt is wide enough for max(MISS_LAT, WR_LAT).
- Reset: state=IDLE, cnt=0, all valid bits=0, fill buffer=0. Backing store is not cleared.
- Reset has priority over everything. Reset during RFILL leaves the line unfilled; reset during WBUSY discards the write.
- IDLE, no request: stall=0, rdata=0.
- IDLE, rmem & !wmem & hit (valid && tag match): rdata = line data combinationally, stall=0. One-cycle access; no state change.
- IDLE, read miss: stall=1 combinationally in the request cycle T; next state RFILL, cnt=MISS_LAT-1.
- RFILL: stall=1; cnt decrements. When cnt==1, load the fill buffer from the backing store, write line/tag, set valid; next state DONE.
  - Net result: stall is high for cycles T..T+MISS_LAT-1.
- IDLE, wmem: stall=1 in cycle T; next state WBUSY, cnt=WR_LAT-1. (rmem&wmem is treated as a write; rdata=0.)
- WBUSY: stall=1; decrement. When cnt==1, write the backing store; if the line hits, update the line data as well (no allocate on miss); next state DONE.
- WR_LAT=1 or MISS_LAT=1: skip the WBUSY/RFILL counting. The commit (or fill) happens on the edge leaving IDLE, and the next state is DONE.
- DONE: stall=0; rdata = fill buffer for reads, 0 for writes. Next state is always IDLE.
  - The request held in DONE is consumed and is not re-evaluated.
  - A new request is evaluated only in the following IDLE cycle.
- Latency summary: read hit = 1 cycle; read miss = MISS_LAT+1 cycles; write = WR_LAT+1 cycles.
- rmem/wmem change while stall=1: protocol violation; the block services the request captured at T.
- Index = word[log2(LINES)-1:0]; tag = remaining word-index bits.

Optional Feature:
- DCACHE_STATS_EN defined: adds outputs hit_count[31:0] and miss_count[31:0].
  - Each increments once per serviced read: hit at the IDLE hit cycle, miss at the IDLE miss cycle. Writes are not counted.
  - Both cleared by reset_0; saturate at 0xFFFFFFFF.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package dcache_pkg holds: the state enum (IDLE, RFILL, WBUSY, DONE), the WORD_W=32 constant, and index/tag width functions derived from LINES and DEPTH.
- One sub-module, dcache_line_store: data, tag and valid arrays with combinational read port, single write port and synchronous valid clear on reset.
- The FSM and backing store stay in the top.

Test Plan:
- After reset, read 0x40 (preload mem[16]=0xDEADBEEF) -> stall high for exactly 4 cycles, then rdata=0xDEADBEEF with stall=0. A repeat read of 0x40 returns 0xDEADBEEF in 1 cycle with stall=0.
- Write 0x40=0x12345678 (line valid) -> stall high for 2 cycles, then a DONE cycle. A following read of 0x40 hits in 1 cycle with 0x12345678.
- Write 0x80=0xA5A5A5A5 (line invalid), then read 0x80 -> the read misses (4 stall cycles), then returns 0xA5A5A5A5, confirming no-write-allocate.
- Conflict: read 0x40, then read 0x40+LINES*4=0x80 (mem=0x11), then read 0x40 -> three misses, each 4 stall cycles; data correct for each.
- Assert reset_0 in the 2nd RFILL cycle of a miss on 0x40 -> stall=0 the cycle after reset; a later read of 0x40 misses again (4 cycles).
- rmem=wmem=1 at 0xC0, wdata=0x77 -> behaves as a write (2 stall cycles, rdata=0). With DCACHE_STATS_EN, after the first scenario: hit_count=1, miss_count=1.
